logic_op_arbiter: RTL
=====================

# logic_op_arbiter

Shares a single registered bitwise logic unit between two requesters. Each requester presents two WIDTH-bit operands and an opcode over a valid/ready handshake. The block arbitrates between them, computes the result in one registered stage and returns it with the winner's ID over a back-pressurable result port. It sits in front of the per-bit OR/AND datapath and replaces direct wiring with a shared, scheduled resource.

## Interface
- CONFIG, 0, arbitration policy: 0 = round-robin; any other value = fixed priority, requester 0 wins
- WIDTH, 4, operand and result width in bits (≥1)
- clock  input  1  sole clock, rising edge
- reset  input  1  synchronous, active-high
- req0_valid  input  1  requester 0 has a request
- req0_ready  output  1  requester 0 request accepted this cycle
- req0_op  input  2  opcode: 0 OR, 1 AND, 2 XOR, 3 NAND
- req0_a, req0_b  input  WIDTH  operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer accepts the result
- res_data  output  WIDTH  bitwise result
- res_id  output  1  ID of the requester that produced res_data
- gnt_count0, gnt_count1  output  8  accepted-request counters, wrap modulo 256

## Operation
- One clock, named clock. Reset is synchronous and active-high, named reset.
- Arbitration is combinational from the valid inputs and the last_id register.
  - Round-robin: if both requesters are valid, grant the one not equal to last_id. If only one is valid, grant it.
  - Fixed priority: requester 0 wins whenever req0_valid is high.
- can_accept = ~res_valid | res_ready.
- reqN_ready = grant_N & can_accept & ~reset. At most one ready is high per cycle.
- On acceptance (reqN_valid & reqN_ready):
  - compute the opcode bit-wise across WIDTH;
  - load the result into res_data and N into res_id;
  - set res_valid = 1;
  - set last_id = N;
  - increment gnt_countN by 1 (255 wraps to 0).
- On res_valid & res_ready with no acceptance in the same cycle: res_valid clears to 0. res_data and res_id hold their values.
- Drain and accept in the same cycle: the new result replaces the old one and res_valid stays 1. This gives full throughput of 1 result/cycle.
- Stall: while res_valid & ~res_ready, both ready outputs are 0. res_data and res_id are held stable.
- Requesters must hold valid, op and operands until they see ready. The arbiter's behaviour does not depend on whether a requester drops valid early.
- Arithmetic is pure bitwise. There is no carry and no width growth.

## Timing
- Reset values: res_valid = 0, res_data = 0, res_id = 0, gnt_count0 = gnt_count1 = 0, last_id = 1 (so requester 0 wins the first contention), req0_ready = req1_ready = 0.
- Latency: a request accepted on edge N has res_valid = 1 with its result after edge N, i.e. in cycle N+1.
- Reset asserted mid-operation: on that edge any pending result is dropped, the counters clear, and no request is accepted.
- reqN_ready has a combinational path from reqN_valid, req(1-N)_valid and res_ready. There is no combinational path from operands or opcode to any output.

## Structure
- Shared package logic_op_pkg holds:
  - opcode localparams OP_OR = 2'd0, OP_AND = 2'd1, OP_XOR = 2'd2, OP_NAND = 2'd3;
  - the ID type;
  - the counter width constant (8).
- One sub-module, logic_op_unit (parameter WIDTH). It is the combinational bitwise function of (op, a, b), built with a generate loop over the bits.
- Arbiter, result register and counters live in the top module.

## Test plan
- Reset then single request: reset 2 cycles; req0 op = OR, a = 4'b1010, b = 4'b0101, res_ready = 1. Required: res_data = 4'b1111, res_id = 0 one cycle after acceptance, gnt_count0 = 1.
- Round-robin contention, CONFIG = 0: both valid continuously for 4 cycles, res_ready = 1. Required: grants 0, 1, 0, 1, one result per cycle, gnt_count0 = gnt_count1 = 2.
- Fixed priority, CONFIG = 1: both valid continuously for 3 cycles. Required: req1_ready never high, gnt_count0 = 3, gnt_count1 = 0.
- Back-pressure: result pending with res_ready = 0 for 3 cycles while req1 is valid (op = NAND, a = 4'hF, b = 4'h3). Required: ready outputs low, res_data stable. When res_ready rises, the next result is 4'hC with res_id = 1, and the drain and accept happen in the same cycle.
- Counter wrap: 256 accepted requests from req1. Required: gnt_count1 returns to 0; gnt_count0 is unchanged.
- Reset mid-stream: assert reset while res_valid = 1 during contention. Required: after the reset edge, res_valid = 0, counters = 0, no ready high. The first contention after reset goes to requester 0.

Source files
------------

// File: rtl/logic_op_pkg.sv
// Shared definitions for the logic-op arbiter slice: opcodes, requester ID
// type, grant-counter width and the single-bit logic function.
package logic_op_pkg;

  localparam logic [1:0] OP_OR   = 2'd0;
  localparam logic [1:0] OP_AND  = 2'd1;
  localparam logic [1:0] OP_XOR  = 2'd2;
  localparam logic [1:0] OP_NAND = 2'd3;

  typedef logic req_id_t;

  localparam int CNT_W = 8;
  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic bit_op(input logic [1:0] op, input logic a, input logic b);
    case (op)
      OP_OR:   return a | b;
      OP_AND:  return a & b;
      OP_XOR:  return a ^ b;
      default: return ~(a & b);
    endcase
  endfunction

endpackage

// File: rtl/logic_op_unit.sv
// Combinational bitwise logic unit: applies one opcode independently to every
// bit position of the two operands.
module logic_op_unit
  import logic_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign y[i] = bit_op(op, a[i], b[i]);
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Two-requester arbiter in front of a shared logic unit with one registered
// result stage, back-pressurable result port and per-requester grant counters.
module logic_op_arbiter
  import logic_op_pkg::*;
#(
  parameter int CONFIG = 0,
  parameter int WIDTH  = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_id,
  output logic [CNT_W-1:0] gnt_count0,
  output logic [CNT_W-1:0] gnt_count1
);

  req_id_t          last_id;
  logic             grant0;
  logic             grant1;
  logic             can_accept;
  logic             acc0;
  logic             acc1;
  logic             accept;
  req_id_t          sel_id;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] unit_y;

  // NOTE: grants get a default before any branch so no path leaves them
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (CONFIG != 0) begin
      grant0 = req0_valid;
      grant1 = ~req0_valid & req1_valid;
    end else if (req0_valid & req1_valid) begin
      // last_id == 1 means requester 1 won last time, so requester 0 goes now.
      grant0 = last_id;
      grant1 = ~last_id;
    end else begin
      grant0 = req0_valid;
      grant1 = req1_valid;
    end
  end

  assign can_accept = ~res_valid | res_ready;
  assign req0_ready = grant0 & can_accept & ~reset;
  assign req1_ready = grant1 & can_accept & ~reset;

  assign acc0   = req0_valid & req0_ready;
  assign acc1   = req1_valid & req1_ready;
  assign accept = acc0 | acc1;
  assign sel_id = acc1;

  assign sel_op = acc1 ? req1_op : req0_op;
  assign sel_a  = acc1 ? req1_a  : req0_a;
  assign sel_b  = acc1 ? req1_b  : req0_b;

  logic_op_unit #(.WIDTH(WIDTH)) u_unit (
    .op (sel_op),
    .a  (sel_a),
    .b  (sel_b),
    .y  (unit_y)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      last_id   <= 1'b1;
    end else if (accept) begin
      // A same-cycle drain is implied: the new result simply overwrites.
      res_valid <= 1'b1;
      res_data  <= unit_y;
      res_id    <= sel_id;
      last_id   <= sel_id;
    end else if (res_ready) begin
      res_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_count0 <= '0;
      gnt_count1 <= '0;
    end else begin
      if (acc0) gnt_count0 <= gnt_count0 + cnt_t'(1);
      if (acc1) gnt_count1 <= gnt_count1 + cnt_t'(1);
    end
  end

endmodule
